evrisim_birimi: RTL and testbench

Streaming 3x3 convolution unit for 8-bit grayscale frames (default 320x240), fed one pixel per accepted cycle in raster order. Applies a runtime-loadable signed 3x3 kernel with zero padding at frame borders. Produces exactly one output pixel per input pixel, plus a parallel fixed-Laplacian edge output. Sits between the pixel source and the downstream filtering/edge stages of the vision pipeline.

---
 rtl/evrisim_birimi_if.sv | 21 ++
 rtl/evrisim_birimi.sv | 221 ++++++++++++++++++++++
 tb/tb_evrisim_birimi.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/evrisim_birimi_if.sv
// Pixel/kernel stream bundle between the pixel source (master) and the convolution unit (slave).
interface evrisim_birimi_if;
  logic        filtre_etkin_i;
  logic [71:0] filtre_i;
  logic        gaus_i;
  logic        veri_etkin_i;
  logic [7:0]  veri_i;
  logic        veri_etkin_o;
  logic [7:0]  veri_o;
  logic [7:0]  laplacian_pixel_o;

  modport master (
    output filtre_etkin_i, filtre_i, gaus_i, veri_etkin_i, veri_i,
    input  veri_etkin_o, veri_o, laplacian_pixel_o
  );

  modport slave (
    input  filtre_etkin_i, filtre_i, gaus_i, veri_etkin_i, veri_i,
    output veri_etkin_o, veri_o, laplacian_pixel_o
  );
endinterface

// File: rtl/evrisim_birimi.sv
// Streaming 3x3 convolution with zero padding, plus a fixed-Laplacian edge output.
module evrisim_birimi #(
  parameter int unsigned IMG_W = 320,
  parameter int unsigned IMG_H = 240
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  evrisim_birimi_if.slave bus
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned AW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned CW   = $clog2(NPIX);
  localparam int unsigned FW   = $clog2(IMG_W + 1);
  localparam int unsigned PW   = 17;
  localparam int unsigned SW   = 20;
  localparam int unsigned LW   = 12;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e               st_q, st_d;
  logic                 shift_c, produce_c;
  logic [7:0]           px_c;
  logic [CW-1:0]        in_cnt_q;
  logic [FW-1:0]        fl_cnt_q;
  logic [AW-1:0]        lb_addr_q, out_col_q;
  logic [RW-1:0]        out_row_q;
  logic [71:0]          filt_q;
  logic                 gaus_q, gaus1_q;
  logic [7:0]           lb0_q [IMG_W];
  logic [7:0]           lb1_q [IMG_W];
  logic [7:0]           win_q [3][3];
  logic                 wv_q, m_top_q, m_bot_q, m_lft_q, m_rgt_q;
  logic [7:0]           tap_c [9];
  logic signed [PW-1:0] prod_c [9];
  logic signed [PW-1:0] prod_q [9];
  logic signed [LW-1:0] lap_c, lap_q, lap_abs_c;
  logic                 vld1_q;
  logic signed [SW-1:0] sum_c, norm_c;
  logic [7:0]           pix_c, lap8_c;
  logic                 vo_vld_q;
  logic [7:0]           vo_q, lo_q;

  // State register: normal streaming vs. end-of-frame flush.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) st_q <= ST_RUN;
    else         st_q <= st_d;
  end

  // Next state: flush after the last pixel of the frame, for IMG_W+1 cycles.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_RUN:   if (bus.veri_etkin_i && in_cnt_q == CW'(NPIX - 1)) st_d = ST_FLUSH;
      ST_FLUSH: if (fl_cnt_q == FW'(IMG_W)) st_d = ST_RUN;
      default:  st_d = ST_RUN;
    endcase
  end

  // Outputs: window shift strobe, pixel pushed and whether this shift yields an output.
  always_comb begin
    shift_c   = 1'b0;
    produce_c = 1'b0;
    px_c      = '0;
    case (st_q)
      ST_RUN: begin
        shift_c   = bus.veri_etkin_i;
        px_c      = bus.veri_i;
        produce_c = bus.veri_etkin_i && (in_cnt_q >= CW'(IMG_W + 1));
      end
      ST_FLUSH: begin
        shift_c   = 1'b1;
        produce_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame position counters: input count, flush count, line-buffer address, output raster position.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      in_cnt_q  <= '0;
      fl_cnt_q  <= '0;
      lb_addr_q <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
    end else begin
      if (st_q == ST_RUN) begin
        fl_cnt_q <= '0;
        if (bus.veri_etkin_i)
          in_cnt_q <= (in_cnt_q == CW'(NPIX - 1)) ? '0 : in_cnt_q + CW'(1);
      end else begin
        fl_cnt_q <= fl_cnt_q + FW'(1);
      end
      if (shift_c)
        lb_addr_q <= (lb_addr_q == AW'(IMG_W - 1)) ? '0 : lb_addr_q + AW'(1);
      if (produce_c) begin
        if (out_col_q == AW'(IMG_W - 1)) begin
          out_col_q <= '0;
          out_row_q <= (out_row_q == RW'(IMG_H - 1)) ? '0 : out_row_q + RW'(1);
        end else begin
          out_col_q <= out_col_q + AW'(1);
        end
      end
    end
  end

  // Kernel register; a strobe takes effect for the window formed on the same edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      filt_q <= '0;
      gaus_q <= 1'b0;
    end else if (bus.filtre_etkin_i) begin
      filt_q <= bus.filtre_i;
      gaus_q <= bus.gaus_i;
    end
  end

  // Line buffers: lb1 delays the stream by one row, lb0 by two; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (shift_c) begin
      lb1_q[lb_addr_q] <= px_c;
      lb0_q[lb_addr_q] <= lb1_q[lb_addr_q];
    end
  end

  // Window shift plus border masks of the output pixel that sits in its centre.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      wv_q    <= 1'b0;
      m_top_q <= 1'b0;
      m_bot_q <= 1'b0;
      m_lft_q <= 1'b0;
      m_rgt_q <= 1'b0;
    end else begin
      wv_q <= produce_c;
      if (shift_c) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb0_q[lb_addr_q];
        win_q[1][2] <= lb1_q[lb_addr_q];
        win_q[2][2] <= px_c;
        m_top_q     <= (out_row_q == '0);
        m_bot_q     <= (out_row_q == RW'(IMG_H - 1));
        m_lft_q     <= (out_col_q == '0);
        m_rgt_q     <= (out_col_q == AW'(IMG_W - 1));
      end
    end
  end

  // Zero the taps that fall outside the frame; the stream is linear so wrap-around taps are masked here.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        tap_c[3*r+c] = win_q[r][c];
        if ((r == 0 && m_top_q) || (r == 2 && m_bot_q) || (c == 0 && m_lft_q) || (c == 2 && m_rgt_q))
          tap_c[3*r+c] = '0;
      end
    end
  end

  // Signed 9x8 products and the fixed Laplacian sum.
  always_comb begin
    for (int i = 0; i < 9; i++)
      prod_c[i] = PW'($signed({1'b0, tap_c[i]})) * PW'($signed(filt_q[71-8*i -: 8]));
    lap_c = $signed({2'b00, tap_c[4], 2'b00}) - $signed({4'h0, tap_c[1]}) - $signed({4'h0, tap_c[3]})
          - $signed({4'h0, tap_c[5]}) - $signed({4'h0, tap_c[7]});
  end

  // Pipeline stage 1: register products.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      lap_q   <= '0;
      gaus1_q <= 1'b0;
      vld1_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_c[i];
      lap_q   <= lap_c;
      gaus1_q <= gaus_q;
      vld1_q  <= wv_q;
    end
  end

  // Sum, optional >>>4 normalisation, clamp to 0..255; Laplacian magnitude saturated at 255.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < 9; i++) sum_c = sum_c + SW'(prod_q[i]);
    norm_c = gaus1_q ? (sum_c >>> 4) : sum_c;
    if (norm_c < 20'sd0)        pix_c = 8'd0;
    else if (norm_c > 20'sd255) pix_c = 8'd255;
    else                        pix_c = norm_c[7:0];
    lap_abs_c = lap_q[LW-1] ? -lap_q : lap_q;
    lap8_c    = (lap_abs_c > 12'sd255) ? 8'd255 : lap_abs_c[7:0];
  end

  // Pipeline stage 2: registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vo_vld_q <= 1'b0;
      vo_q     <= '0;
      lo_q     <= '0;
    end else begin
      vo_vld_q <= vld1_q;
      if (vld1_q) begin
        vo_q <= pix_c;
        lo_q <= lap8_c;
      end
    end
  end

  assign bus.veri_etkin_o      = vo_vld_q;
  assign bus.veri_o            = vo_q;
  assign bus.laplacian_pixel_o = lo_q;

endmodule

// File: tb/tb_evrisim_birimi.sv
// Directed bench for evrisim_birimi on a small 8x6 frame.
module tb_evrisim_birimi;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;

  localparam logic [71:0] K_ID    = 72'h00_00_00_00_01_00_00_00_00;
  localparam logic [71:0] K_ONES  = 72'h01_01_01_01_01_01_01_01_01;
  localparam logic [71:0] K_GAUS  = 72'h01_02_01_02_04_02_01_02_01;
  localparam logic [71:0] K_NEG   = 72'hFF_FF_FF_FF_FF_FF_FF_FF_FF;
  localparam logic [71:0] K_POS   = 72'h7F_7F_7F_7F_7F_7F_7F_7F_7F;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;
  int   cyc = 0;
  int   first_in_cyc;
  int   last_in_cyc;

  logic [7:0] pix  [NPIX];
  logic [7:0] pix2 [NPIX];
  logic [7:0] oq [$];
  logic [7:0] lq [$];
  int         tq [$];

  evrisim_birimi_if bus ();

  evrisim_birimi #(.IMG_W(W), .IMG_H(H)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every output pulse, away from the active edge.
  always @(negedge clk) begin
    if (bus.veri_etkin_o) begin
      oq.push_back(bus.veri_o);
      lq.push_back(bus.laplacian_pixel_o);
      tq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // 0 = interior, 1 = edge, 2 = corner
  function automatic int cls(input int n);
    int k;
    k = 0;
    if (n / W == 0 || n / W == H - 1) k++;
    if (n % W == 0 || n % W == W - 1) k++;
    return k;
  endfunction

  // Feed pix[] in raster order; optional random gaps, kernel strobe with the first pixel,
  // and junk pixels offered during the flush that must be dropped.
  task automatic send_frame(input int gap_pct, input bit ld, input logic [71:0] k, input bit g,
                            input bit junk);
    for (int i = 0; i < NPIX; i++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        bus.veri_etkin_i   = 1'b0;
        bus.filtre_etkin_i = 1'b0;
        bus.veri_i         = 8'($urandom);
      end
      @(negedge clk);
      bus.veri_etkin_i   = 1'b1;
      bus.veri_i         = pix[i];
      bus.filtre_etkin_i = ld && (i == 0);
      bus.filtre_i       = k;
      bus.gaus_i         = g;
      if (i == 0)        first_in_cyc = cyc + 1;
      if (i == NPIX - 1) last_in_cyc  = cyc + 1;
    end
    for (int j = 0; j < W + 1; j++) begin
      @(negedge clk);
      bus.filtre_etkin_i = 1'b0;
      bus.veri_etkin_i   = junk && (j < W);
      bus.veri_i         = 8'hFF;
    end
  endtask

  task automatic wait_outputs(input string tag, input int nexp);
    int t;
    t = 0;
    while (oq.size() < nexp && t < 500) begin
      @(negedge clk);
      bus.veri_etkin_i = 1'b0;
      t++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, oq.size(), nexp);
  endtask

  task automatic check_ident(input string tag, input int base, input logic [7:0] ref_px [NPIX]);
    for (int n = 0; n < NPIX; n++)
      if (base + n < oq.size())
        chk($sformatf("%s[%0d]", tag, n), int'(oq[base+n]), int'(ref_px[n]));
  endtask

  task automatic check_const(input string tag, input int ei, input int ee, input int ec,
                             input int li, input int le, input int lc);
    int e, l;
    for (int n = 0; n < NPIX; n++) begin
      if (n < oq.size()) begin
        e = (cls(n) == 2) ? ec : (cls(n) == 1) ? ee : ei;
        l = (cls(n) == 2) ? lc : (cls(n) == 1) ? le : li;
        chk($sformatf("%s_pix[%0d]", tag, n), int'(oq[n]), e);
        chk($sformatf("%s_lap[%0d]", tag, n), int'(lq[n]), l);
      end
    end
  endtask

  task automatic clear_q();
    oq.delete();
    lq.delete();
    tq.delete();
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < NPIX; i++) pix[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    bus.filtre_etkin_i = 1'b0;
    bus.filtre_i       = '0;
    bus.gaus_i         = 1'b0;
    bus.veri_etkin_i   = 1'b0;
    bus.veri_i         = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld", int'(bus.veri_etkin_o), 0);
    chk("rst_veri", int'(bus.veri_o), 0);
    chk("rst_lap", int'(bus.laplacian_pixel_o), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Identity kernel, random frame, continuous valid, junk offered during flush.
    fill_rand();
    send_frame(0, 1'b1, K_ID, 1'b0, 1'b1);
    wait_outputs("id", NPIX);
    check_ident("id", 0, pix);
    chk("first_lat", (tq.size() > 0) ? tq[0] - first_in_cyc : -1, W + 3);
    chk("last_lat", (tq.size() > 0) ? tq[tq.size()-1] - last_in_cyc : -1, W + 3);
    clear_q();

    // All-ones kernel on constant 10.
    fill_const(8'd10);
    send_frame(0, 1'b1, K_ONES, 1'b0, 1'b0);
    wait_outputs("ones", NPIX);
    check_const("ones", 90, 60, 40, 0, 10, 20);
    clear_q();

    // Binomial kernel with >>>4 on constant 16.
    fill_const(8'd16);
    send_frame(0, 1'b1, K_GAUS, 1'b1, 1'b1);
    wait_outputs("gaus", NPIX);
    check_const("gaus", 16, 12, 9, 0, 16, 32);
    clear_q();

    // Negative clamp: all -1 on constant 200.
    fill_const(8'd200);
    send_frame(0, 1'b1, K_NEG, 1'b0, 1'b0);
    wait_outputs("neg", NPIX);
    check_const("neg", 0, 0, 0, 0, 200, 255);
    clear_q();

    // Positive clamp: all 127 on constant 255.
    fill_const(8'd255);
    send_frame(0, 1'b1, K_POS, 1'b0, 1'b0);
    wait_outputs("pos", NPIX);
    check_const("pos", 255, 255, 255, 0, 255, 255);
    clear_q();

    // Identity with ~30% input gaps.
    fill_rand();
    send_frame(30, 1'b1, K_ID, 1'b0, 1'b0);
    wait_outputs("gap", NPIX);
    check_ident("gap", 0, pix);
    clear_q();

    // Reset in the middle of a frame.
    fill_rand();
    for (int i = 0; i < NPIX / 2; i++) begin
      @(negedge clk);
      bus.veri_etkin_i   = 1'b1;
      bus.veri_i         = pix[i];
      bus.filtre_etkin_i = (i == 0);
      bus.filtre_i       = K_ID;
      bus.gaus_i         = 1'b0;
    end
    @(negedge clk);
    bus.veri_etkin_i   = 1'b0;
    bus.filtre_etkin_i = 1'b0;
    rstn               = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_vld", int'(bus.veri_etkin_o), 0);
    chk("midrst_veri", int'(bus.veri_o), 0);
    rstn = 1'b1;
    clear_q();

    // Restart (kernel was cleared, so reload), then a back-to-back frame keeping the kernel.
    fill_rand();
    send_frame(0, 1'b1, K_ID, 1'b0, 1'b0);
    for (int i = 0; i < NPIX; i++) pix2[i] = pix[i];
    fill_rand();
    send_frame(0, 1'b0, K_ID, 1'b0, 1'b0);
    wait_outputs("b2b", 2 * NPIX);
    check_ident("rst_f1", 0, pix2);
    check_ident("rst_f2", NPIX, pix);
    clear_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
